// File: rtl/jtdd_obj_pkg.sv
// jtdd_obj_pkg: scan FSM states, attribute bit positions and entry stride for the object layer
package jtdd_obj_pkg;
   typedef enum logic [2:0] {IDLE, READ, CHECK, FETCH, DRAW, NEXT} state_t;
   localparam int ATTR_EN      = 7;
   localparam int ATTR_TALL    = 4;
   localparam int ATTR_FLIPX   = 3;
   localparam int ATTR_FLIPY   = 2;
   localparam int ATTR_X8      = 1;
   localparam int ATTR_Y8      = 0;
   localparam int ENTRY_STRIDE = 8;
endpackage

// File: rtl/jtdd_obj_linebuf.sv
// jtdd_obj_linebuf: double 256x8 line buffer; clk-rate draw writes, pxl_cen reads with clear-after-read
module jtdd_obj_linebuf (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       pxl_cen_i,
   input  logic       bank_i,
   input  logic       we_i,
   input  logic [7:0] waddr_i,
   input  logic [7:0] wdata_i,
   input  logic [7:0] raddr_i,
   input  logic       hbl_i,
   output logic [7:0] pxl_o
);
   logic [7:0] mem [0:511];
   logic [7:0] pxl_q;
   logic       clr_q;
   logic [8:0] clr_a_q;
   // read the non-drawing bank and remember the location so it is wiped one clk later
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         pxl_q   <= '0;
         clr_q   <= 1'b0;
         clr_a_q <= '0;
      end else begin
         clr_q <= pxl_cen_i & ~hbl_i;
         if (pxl_cen_i) begin
            pxl_q   <= hbl_i ? 8'd0 : mem[{~bank_i, raddr_i}];
            clr_a_q <= {~bank_i, raddr_i};
         end
      end
   // storage: draw writes go to the drawing bank, clears to the bank just read
   always_ff @(posedge clk_i) begin
      if (we_i) mem[{bank_i, waddr_i}] <= wdata_i;
      if (clr_q) mem[clr_a_q] <= 8'd0;
   end
   assign pxl_o = pxl_q;
endmodule

// File: rtl/jtdd_obj.sv
// jtdd_obj: object layer (RAM scan, ROM fetch, line buffer); JTDD_OBJ_TALL_EN enables 16x32 objects
module jtdd_obj
   import jtdd_obj_pkg::*;
#(
   parameter int OBJMAX = 64,
   parameter int ROMW   = 18
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pxl_cen,
   input  logic [8:0]      cpu_AB,
   input  logic            obj_cs,
   input  logic            cpu_wrn,
   input  logic [7:0]      cpu_dout,
   input  logic            cen_E,
   output logic [7:0]      obj_dout,
   input  logic [7:0]      HPOS,
   input  logic [7:0]      VPOS,
   input  logic            HBL,
   input  logic            flip,
   output logic [ROMW-1:0] rom_addr,
   input  logic [15:0]     rom_data,
   input  logic            rom_ok,
   output logic [7:0]      obj_pxl
);
   localparam int NW = $clog2(OBJMAX);
   logic [7:0]      ram [0:511];
   logic [7:0]      dout_q, rd, waddr;
   state_t          st_q, st_d;
   logic [NW-1:0]   n_q, n_d;
   logic [2:0]      b_q, b_d;
   logic [1:0]      w_q, w_d, k_q, k_d;
   logic            bank_q, bank_d, hbl_q, en_q, en_d, fx_q, fx_d, fy_q, fy_d, tall_q, tall_d;
   logic [8:0]      line_q, line_d, y_q, y_d, x_q, x_d, dy, xs;
   logic [3:0]      col_q, col_d, row_q, row_d, r0, row, p, nib;
   logic [11:0]     code_q, code_d, fc_q, fc_d, fc;
   logic [15:0]     word_q, word_d;
   logic [ROMW-1:0] rom_addr_q, rom_addr_d;
   logic            vis, half, start, we;
   // CPU port of the object RAM
   always_ff @(posedge clk)
      if (obj_cs & ~cpu_wrn & cen_E) ram[cpu_AB] <= cpu_dout;
   // CPU read-back, one clk latency
   always_ff @(posedge clk or negedge rst)
      if (!rst) dout_q <= '0;
      else dout_q <= ram[cpu_AB];
   assign rd    = ram[9'(ENTRY_STRIDE * n_q + b_q)];
   assign start = HBL & ~hbl_q;
   assign dy    = line_q - y_q;
   assign vis   = en_q & ~|dy[8:5] & (tall_q | ~dy[4]);
   assign r0    = flip ? ~dy[3:0] : dy[3:0];
   assign row   = fy_q ? ~r0 : r0;
   assign half  = tall_q & (dy[4] ^ fy_q);
   assign fc    = code_q + {11'd0, half};
   assign p     = fx_q ? ~{w_q, k_q} : {w_q, k_q};
   assign nib   = 4'(word_q >> {~k_q, 2'b00});
   assign xs    = x_q + {5'd0, p};
   assign we    = (st_q == DRAW) & ~xs[8] & |nib;
   assign waddr = flip ? ~xs[7:0] : xs[7:0];
   // scan sequencer: line start, entry load, visibility, ROM fetch and pixel draw
   always_comb begin
      st_d = st_q; n_d = n_q; b_d = b_q; w_d = w_q; k_d = k_q; bank_d = bank_q; line_d = line_q;
      y_d = y_q; x_d = x_q; en_d = en_q; fx_d = fx_q; fy_d = fy_q; tall_d = tall_q; col_d = col_q;
      code_d = code_q; row_d = row_q; fc_d = fc_q; word_d = word_q; rom_addr_d = rom_addr_q;
      if (start) begin
         st_d   = READ;
         n_d    = '0;
         b_d    = '0;
         bank_d = ~bank_q;
         line_d = {1'b0, VPOS + 8'd1};
      end else case (st_q)
         READ: begin
            b_d  = b_q == 3'd4 ? 3'd0 : b_q + 3'd1;
            st_d = b_q == 3'd4 ? CHECK : READ;
            if (b_q == 3'd0) y_d[7:0] = rd;
            if (b_q == 3'd1) begin
               en_d   = rd[ATTR_EN];
               fx_d   = rd[ATTR_FLIPX];
               fy_d   = rd[ATTR_FLIPY];
               x_d[8] = rd[ATTR_X8];
               y_d[8] = rd[ATTR_Y8];
`ifdef JTDD_OBJ_TALL_EN
               tall_d = rd[ATTR_TALL];
`else
               tall_d = 1'b0;
`endif
            end
            if (b_q == 3'd2) {col_d, code_d[11:8]} = rd;
            if (b_q == 3'd3) code_d[7:0] = rd;
            if (b_q == 3'd4) x_d[7:0] = rd;
         end
         CHECK: begin
            st_d  = vis ? FETCH : NEXT;
            w_d   = '0;
            row_d = row;
            fc_d  = fc;
            if (vis) rom_addr_d = ROMW'({fc, row, 2'b00});
         end
         FETCH: if (rom_ok) begin
            word_d = rom_data;
            k_d    = '0;
            st_d   = DRAW;
         end
         DRAW: begin
            k_d = k_q + 2'd1;
            if (k_q == 2'd3) begin
               st_d = w_q == 2'd3 ? NEXT : FETCH;
               w_d  = w_q + 2'd1;
               if (w_q != 2'd3) rom_addr_d = ROMW'({fc_q, row_q, w_q + 2'd1});
            end
         end
         NEXT: begin
            st_d = n_q == NW'(OBJMAX - 1) ? IDLE : READ;
            n_d  = n_q + 1'b1;
            b_d  = '0;
         end
         default: ;
      endcase
   end
   // scan state registers
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         st_q <= IDLE; n_q <= '0; b_q <= '0; w_q <= '0; k_q <= '0; bank_q <= 1'b0; hbl_q <= 1'b0;
         line_q <= '0; y_q <= '0; x_q <= '0; en_q <= 1'b0; fx_q <= 1'b0; fy_q <= 1'b0; tall_q <= 1'b0;
         col_q <= '0; code_q <= '0; row_q <= '0; fc_q <= '0; word_q <= '0; rom_addr_q <= '0;
      end else begin
         st_q <= st_d; n_q <= n_d; b_q <= b_d; w_q <= w_d; k_q <= k_d; bank_q <= bank_d; hbl_q <= HBL;
         line_q <= line_d; y_q <= y_d; x_q <= x_d; en_q <= en_d; fx_q <= fx_d; fy_q <= fy_d; tall_q <= tall_d;
         col_q <= col_d; code_q <= code_d; row_q <= row_d; fc_q <= fc_d; word_q <= word_d; rom_addr_q <= rom_addr_d;
      end
   jtdd_obj_linebuf u_linebuf (
      .clk_i     (clk),
      .rst_ni    (rst),
      .pxl_cen_i (pxl_cen),
      .bank_i    (bank_q),
      .we_i      (we),
      .waddr_i   (waddr),
      .wdata_i   ({col_q, nib}),
      .raddr_i   (HPOS),
      .hbl_i     (HBL),
      .pxl_o     (obj_pxl)
   );
   assign obj_dout = dout_q;
   assign rom_addr = rom_addr_q;
endmodule

// File: tb/tb_jtdd_obj.sv
// tb_jtdd_obj: directed and random line rendering against a per-line sprite model
module tb_jtdd_obj;
   logic clk = 1'b0, rst = 1'b0, pxl_cen = 1'b0, obj_cs = 1'b0, cpu_wrn = 1'b1, cen_E = 1'b0;
   logic HBL = 1'b0, flip = 1'b0, rom_ok;
   logic [8:0]  cpu_AB = '0;
   logic [7:0]  cpu_dout = '0, HPOS = '0, VPOS = '0, obj_dout, obj_pxl;
   logic [17:0] rom_addr, last_addr = '0;
   logic [15:0] rom_data;
   logic [7:0]  ram_m [0:511];
   logic [7:0]  exp_l [0:255];
   int checks = 0, failures = 0, stall = 0, stall_cnt = 0, chg = 0, chg0;
`ifdef JTDD_OBJ_TALL_EN
   localparam bit TALL = 1'b1;
`else
   localparam bit TALL = 1'b0;
`endif
   localparam int SCAN = 1200;
   always #5 clk = ~clk;
   jtdd_obj dut (
      .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .cpu_AB(cpu_AB), .obj_cs(obj_cs), .cpu_wrn(cpu_wrn),
      .cpu_dout(cpu_dout), .cen_E(cen_E), .obj_dout(obj_dout), .HPOS(HPOS), .VPOS(VPOS), .HBL(HBL),
      .flip(flip), .rom_addr(rom_addr), .rom_data(rom_data), .rom_ok(rom_ok), .obj_pxl(obj_pxl)
   );
   function automatic logic [15:0] rom_fn(logic [17:0] a);
      if (a[17:6] == 12'h005) return 16'h7777;
      if (a[17:6] == 12'h009)
         return a[1:0] == 2'd0 ? 16'h1234 : a[1:0] == 2'd1 ? 16'h5678 : a[1:0] == 2'd2 ? 16'h9ABC : 16'hDEF0;
      return {a[5:0], a[17:8]} ^ 16'hA5C3;
   endfunction
   assign rom_data = rom_fn(rom_addr);
   assign rom_ok   = (rom_addr == last_addr) && (stall_cnt >= stall);
   always @(posedge clk) begin
      if (rom_addr != last_addr) begin
         chg       <= chg + 1;
         stall_cnt <= 0;
      end else stall_cnt <= stall_cnt + 1;
      last_addr <= rom_addr;
   end
   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic cpu_wr(int a, logic [7:0] d);
      @(negedge clk);
      cpu_AB = 9'(a); cpu_dout = d; obj_cs = 1'b1; cpu_wrn = 1'b0; cen_E = 1'b1;
      ram_m[a] = d;
      @(negedge clk);
      obj_cs = 1'b0; cpu_wrn = 1'b1; cen_E = 1'b0;
   endtask
   task automatic cpu_rd(int a, string tag);
      @(negedge clk);
      cpu_AB = 9'(a);
      @(negedge clk);
      check(tag, obj_dout, ram_m[a]);
   endtask
   task automatic set_entry(int n, logic [7:0] y, logic [7:0] at, logic [3:0] col, logic [11:0] code, logic [7:0] x);
      cpu_wr(n * 8, y);
      cpu_wr(n * 8 + 1, at);
      cpu_wr(n * 8 + 2, {col, code[11:8]});
      cpu_wr(n * 8 + 3, code[7:0]);
      cpu_wr(n * 8 + 4, x);
   endtask
   task automatic clear_all();
      for (int n = 0; n < 64; n++) cpu_wr(n * 8 + 1, 8'h00);
   endtask
   // expected finished line: entries painted in order, later ones on top
   task automatic build_exp(int t);
      for (int i = 0; i < 256; i++) exp_l[i] = 8'h00;
      for (int n = 0; n < 64; n++) begin
         logic [7:0] at;
         int y9, x9, dy, r, h, code, col, x, nib, pp;
         logic [15:0] word;
         at = ram_m[n * 8 + 1];
         if (!at[7]) continue;
         y9 = {23'd0, at[0], ram_m[n * 8]};
         x9 = {23'd0, at[1], ram_m[n * 8 + 4]};
         dy = (t - y9 + 512) % 512;
         if (dy >= ((TALL && at[4]) ? 32 : 16)) continue;
         r = dy % 16;
         if (flip) r = 15 - r;
         if (at[2]) r = 15 - r;
         h = (TALL && at[4]) ? ((dy >= 16) != at[2]) : 0;
         code = ({20'd0, ram_m[n * 8 + 2][3:0], ram_m[n * 8 + 3]} + h) % 4096;
         col = {28'd0, ram_m[n * 8 + 2][7:4]};
         for (int s = 0; s < 16; s++) begin
            word = rom_fn(18'(code * 64 + r * 4 + s / 4));
            nib = (word >> (4 * (3 - s % 4))) & 15;
            pp = at[3] ? 15 - s : s;
            x = (x9 + pp) % 512;
            if (x < 256 && nib != 0) exp_l[flip ? 255 - x : x] = 8'(col * 16 + nib);
         end
      end
   endtask
   task automatic run_line(logic [7:0] vpos, bit chk, string tag);
      @(negedge clk);
      VPOS = vpos; HBL = 1'b1;
      repeat (2) @(negedge clk);
      HPOS = 8'h45; pxl_cen = 1'b1;
      @(negedge clk);
      pxl_cen = 1'b0;
      if (chk) check({tag, "_hbl"}, obj_pxl, 8'h00);
      repeat (SCAN) @(negedge clk);
      HBL = 1'b0; pxl_cen = 1'b1;
      for (int h = 0; h < 256; h++) begin
         HPOS = 8'(h);
         @(negedge clk);
         if (chk) check($sformatf("%s_px%02h", tag, h), obj_pxl, exp_l[h]);
      end
      pxl_cen = 1'b0;
   endtask
   task automatic do_test(logic [7:0] t, string tag);
      build_exp(t);
      run_line(t - 8'd1, 1'b0, tag);
      run_line(8'hEF, 1'b1, tag);
   endtask
   initial begin
      logic [7:0] t;
      repeat (3) @(negedge clk);
      check("rst_obj_pxl", obj_pxl, 8'h00);
      check("rst_obj_dout", obj_dout, 8'h00);
      check("rst_rom_addr", rom_addr, 18'h0);
      rst = 1'b1;
      for (int a = 0; a < 512; a++) cpu_wr(a, 8'h00);
      cpu_wr(9'h1A3, 8'h5C);
      cpu_rd(9'h1A3, "cpu_rd_wr");
      @(negedge clk);
      cpu_AB = 9'h1A4; cpu_dout = 8'hAA; obj_cs = 1'b1; cpu_wrn = 1'b0; cen_E = 1'b0;
      @(negedge clk);
      obj_cs = 1'b0; cpu_wrn = 1'b1;
      cpu_rd(9'h1A4, "cpu_no_cen");
      cpu_wr(9'h1A3, 8'h00);
      cpu_rd(9'h1A3, "cpu_rd_clr");
      run_line(8'h00, 1'b0, "warm");
      run_line(8'h00, 1'b0, "warm");
      set_entry(0, 8'h20, 8'h80, 4'h3, 12'h005, 8'h40);
      do_test(8'h20, "basic");
      do_test(8'h30, "blank");
      set_entry(0, 8'h20, 8'h80, 4'h3, 12'h005, 8'hF8);
      do_test(8'h20, "edge");
      set_entry(0, 8'h20, 8'h80, 4'h3, 12'h005, 8'h40);
      stall = 20;
      chg0 = chg;
      do_test(8'h20, "stall");
      check("stall_addr_changes", chg - chg0, 4);
      stall = 0;
      set_entry(0, 8'h20, 8'h80, 4'h1, 12'h005, 8'h40);
      set_entry(1, 8'h20, 8'h80, 4'h2, 12'h009, 8'h40);
      do_test(8'h20, "prio");
      cpu_wr(1, 8'h00);
      set_entry(1, 8'h20, 8'h88, 4'h2, 12'h009, 8'h40);
      do_test(8'h20, "flipx");
      clear_all();
      set_entry(0, 8'h20, 8'h90, 4'h3, 12'h005, 8'h40);
      do_test(8'h30, "tall_lo");
      do_test(8'h20, "tall_hi");
      for (int r = 0; r < 4; r++) begin
         flip = r >= 2;
         clear_all();
         t = 8'($urandom_range(16, 239));
         for (int i = 0; i < 6; i++)
            set_entry($urandom_range(0, 63), 8'(t - 8'($urandom_range(0, 31))), 8'h80 | 8'($urandom & 32'h1C),
                      4'($urandom), 12'($urandom_range(0, 15)), 8'($urandom));
         do_test(t, $sformatf("rand%0d", r));
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
